// File: rtl/cpu_control_unit_if.sv
//==============================================================================
// Module  : cpu_control_unit_if
// Brief   : Single-outstanding memory request/ready bus between sequencer and memory.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface cpu_control_unit_if;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/cpu_control_unit.sv
//==============================================================================
// Module  : cpu_control_unit
// Brief   : Accumulator-machine sequencer: fetch, decode, operand read, execute, store.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_control_unit (
    input  wire                       clk,
    input  wire                       reset,
    cpu_control_unit_if.master        bus,
    input  wire [7:0]                 acc_in,
    input  wire                       zero_flag,
    output logic [3:0]                alu_op,
    output logic [7:0]                alu_b,
    output logic                      acc_load,
    output logic [7:0]                pc,
    output logic                      halted,
    output logic                      illegal
);

    localparam logic [3:0] C_OP_NOP = 4'h0;
    localparam logic [3:0] C_OP_LDA = 4'h1;
    localparam logic [3:0] C_OP_STA = 4'h2;
    localparam logic [3:0] C_OP_ADD = 4'h3;
    localparam logic [3:0] C_OP_SUB = 4'h4;
    localparam logic [3:0] C_OP_AND = 4'h5;
    localparam logic [3:0] C_OP_OR  = 4'h6;
    localparam logic [3:0] C_OP_XOR = 4'h7;
    localparam logic [3:0] C_OP_JMP = 4'h8;
    localparam logic [3:0] C_OP_JZ  = 4'h9;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    localparam logic [3:0] C_ALU_ADD  = 4'd0;
    localparam logic [3:0] C_ALU_SUB  = 4'd1;
    localparam logic [3:0] C_ALU_AND  = 4'd2;
    localparam logic [3:0] C_ALU_OR   = 4'd3;
    localparam logic [3:0] C_ALU_XOR  = 4'd4;
    localparam logic [3:0] C_ALU_PASS = 4'd5;

    typedef enum logic [2:0] {
        ST_RST        = 3'd0,
        ST_FETCH_OP   = 3'd1,
        ST_FETCH_ADDR = 3'd2,
        ST_READ       = 3'd3,
        ST_EXEC       = 3'd4,
        ST_WRITE      = 3'd5,
        ST_HALT       = 3'd6
    } state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [3:0] ir_q;
    logic [7:0] ar_q;
    logic [7:0] opnd_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic [7:0] mem_wdata_q;
    logic [3:0] alu_op_q;
    logic       acc_load_q;
    logic       halted_q;
    logic       illegal_q;
    logic [3:0] w_rd_op;
    logic       w_rd_illegal;
    logic [3:0] w_alu_op;

    // IR keeps only the opcode nibble; the low nibble never influences decode.
    assign w_rd_op      = bus.mem_rdata[7:4];
    assign w_rd_illegal = (w_rd_op >= 4'hA) && (w_rd_op <= 4'hE);

    always_comb begin
        pc_d = pc_q + 8'd1;
        if ((state_q == ST_FETCH_ADDR) &&
            ((ir_q == C_OP_JMP) || ((ir_q == C_OP_JZ) && zero_flag))) begin
            pc_d = bus.mem_rdata;
        end
    end

    always_comb begin
        w_alu_op = C_ALU_PASS;
        case (ir_q)
            C_OP_ADD: w_alu_op = C_ALU_ADD;
            C_OP_SUB: w_alu_op = C_ALU_SUB;
            C_OP_AND: w_alu_op = C_ALU_AND;
            C_OP_OR:  w_alu_op = C_ALU_OR;
            C_OP_XOR: w_alu_op = C_ALU_XOR;
            default:  w_alu_op = C_ALU_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RST;
            pc_q        <= 8'h00;
            ir_q        <= 4'h0;
            ar_q        <= 8'h00;
            opnd_q      <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            alu_op_q    <= 4'h0;
            acc_load_q  <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            acc_load_q <= 1'b0;
            unique case (state_q)
                ST_RST: begin
                    state_q   <= ST_FETCH_OP;
                    mem_req_q <= 1'b1;
                end
                ST_FETCH_OP: begin
                    if (bus.mem_ready) begin
                        ir_q <= w_rd_op;
                        pc_q <= pc_d;
                        if ((w_rd_op == C_OP_HLT) || w_rd_illegal) begin
                            state_q   <= ST_HALT;
                            mem_req_q <= 1'b0;
                            halted_q  <= 1'b1;
                            illegal_q <= w_rd_illegal;
                        end else if (w_rd_op != C_OP_NOP) begin
                            state_q <= ST_FETCH_ADDR;
                        end
                    end
                end
                ST_FETCH_ADDR: begin
                    if (bus.mem_ready) begin
                        ar_q <= bus.mem_rdata;
                        pc_q <= pc_d;
                        if ((ir_q == C_OP_JMP) || (ir_q == C_OP_JZ)) begin
                            state_q <= ST_FETCH_OP;
                        end else if (ir_q == C_OP_STA) begin
                            state_q     <= ST_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= acc_in;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.mem_ready) begin
                        opnd_q     <= bus.mem_rdata;
                        alu_op_q   <= w_alu_op;
                        acc_load_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    mem_req_q <= 1'b1;
                    state_q   <= ST_FETCH_OP;
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        mem_we_q <= 1'b0;
                        state_q  <= ST_FETCH_OP;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q   <= ST_RST;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_addr  = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? ar_q : pc_q;

    assign alu_op   = alu_op_q;
    assign alu_b    = opnd_q;
    assign acc_load = acc_load_q;
    assign pc       = pc_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
//==============================================================================
// Module  : tb_cpu_control_unit
// Brief   : Directed and random programs checked against an instruction-level model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_control_unit;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_ACC = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] acc_in;
    logic       zero_flag;
    logic [3:0] alu_op;
    logic [7:0] alu_b;
    logic       acc_load;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;

    int n_total = 0;
    int n_pass  = 0;
    int n_writes;
    int n_accs;
    int wait_lo = 0;
    int wait_hi = 0;
    int last_cyc;
    logic [7:0]  acc_preset = 8'h00;
    logic        z_preset   = 1'b0;
    logic [7:0]  mem       [256];
    logic [7:0]  model_mem [256];
    logic [17:0] dlog [$];
    logic [17:0] mlog [$];

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .acc_in    (acc_in),
        .zero_flag (zero_flag),
        .alu_op    (alu_op),
        .alu_b     (alu_b),
        .acc_load  (acc_load),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h1:    return 4'd5;
            4'h3:    return 4'd0;
            4'h4:    return 4'd1;
            4'h5:    return 4'd2;
            4'h6:    return 4'd3;
            4'h7:    return 4'd4;
            default: return 4'hF;
        endcase
    endfunction

    // Memory responder with random wait states, plus the accumulator/flag the sequencer drives.
    initial begin : responder
        bit         busy;
        int         left;
        logic [7:0] l_addr, l_wdata, r;
        logic       l_we;
        busy = 1'b0;
        left = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'h00;
        acc_in    = 8'h00;
        zero_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                acc_in    = acc_preset;
                zero_flag = z_preset;
            end
            if (reset !== 1'b1 || bus.mem_req !== 1'b1) begin
                busy = 1'b0;
                bus.mem_ready = 1'b0;
            end else begin
                if (!busy) begin
                    busy    = 1'b1;
                    left    = $urandom_range(wait_hi, wait_lo);
                    l_addr  = bus.mem_addr;
                    l_we    = bus.mem_we;
                    l_wdata = bus.mem_wdata;
                end else begin
                    check("hold addr", {24'h0, bus.mem_addr}, {24'h0, l_addr});
                    check("hold we", {31'h0, bus.mem_we}, {31'h0, l_we});
                    if (l_we) check("hold wdata", {24'h0, bus.mem_wdata}, {24'h0, l_wdata});
                end
                if (left == 0) begin
                    busy = 1'b0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                        dlog.push_back({K_WR, bus.mem_addr, bus.mem_wdata});
                        n_writes++;
                    end else begin
                        bus.mem_rdata = mem[bus.mem_addr];
                        dlog.push_back({K_RD, bus.mem_addr, mem[bus.mem_addr]});
                    end
                end else begin
                    left--;
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                end
            end
            if (acc_load === 1'b1) begin
                case (alu_op)
                    4'd0:    r = acc_in + alu_b;
                    4'd1:    r = acc_in - alu_b;
                    4'd2:    r = acc_in & alu_b;
                    4'd3:    r = acc_in | alu_b;
                    4'd4:    r = acc_in ^ alu_b;
                    4'd5:    r = alu_b;
                    default: r = 8'h00;
                endcase
                dlog.push_back({K_ACC, 4'h0, alu_op, alu_b});
                n_accs++;
                acc_in    = r;
                zero_flag = (r == 8'h00);
            end
        end
    end

    task automatic run_model(input int max_instr, output logic [7:0] fpc, output bit fh,
                             output bit fi, output int cost);
        logic [7:0] p, a, b, acc, r;
        logic [3:0] op;
        bit         z;
        p = 8'h00; acc = acc_preset; z = z_preset;
        fh = 1'b0; fi = 1'b0; cost = 0;
        mlog.delete();
        for (int n = 0; n < max_instr && !fh; n++) begin
            op = model_mem[p][7:4];
            mlog.push_back({K_RD, p, model_mem[p]});
            p = p + 8'd1;
            cost += wait_hi + 1;
            if (op == 4'hF || (op >= 4'hA && op <= 4'hE)) begin
                fh = 1'b1;
                fi = (op != 4'hF);
            end else if (op != 4'h0) begin
                a = model_mem[p];
                mlog.push_back({K_RD, p, a});
                p = p + 8'd1;
                cost += wait_hi + 1;
                if (op == 4'h8) begin
                    p = a;
                end else if (op == 4'h9) begin
                    if (z) p = a;
                end else if (op == 4'h2) begin
                    mlog.push_back({K_WR, a, acc});
                    model_mem[a] = acc;
                    cost += wait_hi + 1;
                end else begin
                    b = model_mem[a];
                    mlog.push_back({K_RD, a, b});
                    case (op)
                        4'h1:    r = b;
                        4'h3:    r = acc + b;
                        4'h4:    r = acc - b;
                        4'h5:    r = acc & b;
                        4'h6:    r = acc | b;
                        default: r = acc ^ b;
                    endcase
                    mlog.push_back({K_ACC, 4'h0, exp_alu(op), b});
                    acc  = r;
                    z    = (r == 8'h00);
                    cost += wait_hi + 2;
                end
            end
        end
        fpc = p;
    endtask

    task automatic fill(input logic [7:0] bg);
        for (int i = 0; i < 256; i++) mem[i] = bg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_run();
        model_mem = mem;
        dlog.delete();
        n_writes = 0;
        n_accs   = 0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic compare_run(input string tag, input int budget);
        int         cyc, mcost, n;
        logic [7:0] mpc;
        bit         mh, mi;
        cyc = 0;
        @(negedge clk);
        while (halted !== 1'b1 && cyc < budget) begin
            cyc++;
            @(negedge clk);
        end
        last_cyc = cyc;
        run_model(4000, mpc, mh, mi, mcost);
        if (halted === 1'b1 || (mh && mcost < budget)) begin
            check({tag, " halted"}, {31'h0, halted}, {31'h0, mh});
            check({tag, " illegal"}, {31'h0, illegal}, {31'h0, mi});
            check({tag, " pc"}, {24'h0, pc}, {24'h0, mpc});
            check({tag, " trace len"}, dlog.size(), mlog.size());
        end
        n = (dlog.size() < mlog.size()) ? dlog.size() : mlog.size();
        for (int i = 0; i < n; i++) check({tag, " trace"}, {14'h0, dlog[i]}, {14'h0, mlog[i]});
    endtask

    initial begin : main
        logic [17:0] e;
        logic [3:0]  op_tbl [16];
        bit          found;
        op_tbl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                   4'h8, 4'h9, 4'hF, 4'h1, 4'h3, 4'h2, 4'h9, 4'hB};
        reset = 1'b0;
        fill(8'hF0);
        repeat (3) @(negedge clk);
        check("rst mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst mem_addr", {24'h0, bus.mem_addr}, 32'h0);
        check("rst mem_wdata", {24'h0, bus.mem_wdata}, 32'h0);
        check("rst alu_op", {28'h0, alu_op}, 32'h0);
        check("rst alu_b", {24'h0, alu_b}, 32'h0);
        check("rst acc_load", {31'h0, acc_load}, 32'h0);
        check("rst pc", {24'h0, pc}, 32'h0);
        check("rst halted", {31'h0, halted}, 32'h0);
        check("rst illegal", {31'h0, illegal}, 32'h0);

        // LDA 20; ADD 21; HLT with zero-wait, then with three wait states per transfer
        for (int pass = 0; pass < 2; pass++) begin
            fill(8'hF0);
            mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h21; mem[4] = 8'hF0;
            mem[8'h20] = 8'h05; mem[8'h21] = 8'h03;
            acc_preset = 8'h00; z_preset = 1'b0;
            wait_lo = 3 * pass; wait_hi = 3 * pass;
            do_reset();
            start_run();
            compare_run(pass == 0 ? "lda_add zw" : "lda_add ws", 400);
            check("lda_add cycles", last_cyc, (pass == 0) ? 9 : 30);
            check("lda_add pc", {24'h0, pc}, 32'h05);
            check("lda_add acc", {24'h0, acc_in}, 32'h08);
            check("lda_add loads", n_accs, 2);
        end
        wait_lo = 0; wait_hi = 0;

        fill(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h40;
        acc_preset = 8'h5A;
        do_reset();
        start_run();
        compare_run("sta", 100);
        check("sta writes", n_writes, 1);
        check("sta loads", n_accs, 0);
        check("sta mem", {24'h0, mem[8'h40]}, 32'h5A);
        check("sta pc", {24'h0, pc}, 32'h03);

        for (int zf = 1; zf >= 0; zf--) begin
            fill(8'hF0);
            mem[0] = 8'h90; mem[1] = 8'h10;
            z_preset = zf[0];
            do_reset();
            start_run();
            compare_run("jz", 100);
            e = dlog[2];
            check("jz next fetch", {24'h0, e[15:8]}, zf ? 32'h10 : 32'h02);
            check("jz pc", {24'h0, pc}, zf ? 32'h11 : 32'h03);
        end
        z_preset = 1'b0;

        fill(8'hF0);
        mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h30;
        do_reset();
        start_run();
        compare_run("jmp fe", 100);
        check("jmp fe pc", {24'h0, pc}, 32'h31);

        fill(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'hFF; mem[8'hFF] = 8'h00;
        acc_preset = 8'hF0;
        do_reset();
        start_run();
        compare_run("nop wrap", 100);
        e = dlog[6];
        check("nop wrap fetch", {24'h0, e[15:8]}, 32'h00);
        check("nop wrap pc", {24'h0, pc}, 32'h01);

        fill(8'hF0);
        mem[0] = 8'hB0;
        do_reset();
        start_run();
        compare_run("illegal", 50);
        check("illegal flag", {31'h0, illegal}, 32'h1);
        repeat (3) @(negedge clk);
        check("illegal req", {31'h0, bus.mem_req}, 32'h0);
        check("illegal halted", {31'h0, halted}, 32'h1);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("clr halted", {31'h0, halted}, 32'h0);
        check("clr illegal", {31'h0, illegal}, 32'h0);
        mem[0] = 8'hF0;
        #1 reset = 1'b1;
        check("release req", {31'h0, bus.mem_req}, 32'h0);
        @(negedge clk);
        check("first fetch req", {31'h0, bus.mem_req}, 32'h1);
        check("first fetch addr", {24'h0, bus.mem_addr}, 32'h00);

        fill(8'hF0);
        mem[0] = 8'h10; mem[1] = 8'h20; mem[8'h20] = 8'h77;
        wait_lo = 6; wait_hi = 6;
        do_reset();
        start_run();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (bus.mem_req === 1'b1) && (bus.mem_addr === 8'h20) && (dlog.size() == 2);
        end
        check("read wait reached", {31'h0, found}, 32'h1);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort req", {31'h0, bus.mem_req}, 32'h0);
        check("abort pc", {24'h0, pc}, 32'h00);
        repeat (5) @(negedge clk);
        check("abort loads", n_accs, 0);
        check("abort alu_b", {24'h0, alu_b}, 32'h00);

        for (int run = 0; run < 20; run++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = {op_tbl[$urandom_range(15, 0)], 4'($urandom)};
            end
            acc_preset = 8'($urandom);
            z_preset   = 1'($urandom);
            wait_lo = 0;
            wait_hi = $urandom_range(2, 0);
            do_reset();
            start_run();
            compare_run("random", 2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
